// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined WIDTH-bit bitwise logic unit.
// Stage 1 captures op/a/b on an input handshake; stage 2 holds the registered
// result plus zero/negative/parity flags until the consumer takes it.
// A completed-transaction counter tracks output handshakes and wraps silently.
module logic_unit_pipe #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 zr,
    output logic                 ng,
    output logic                 par,
    output logic [CNT_WIDTH-1:0] out_count
);

    // Bitwise operation table; every encoding is a pure per-bit function.
    function automatic logic [WIDTH-1:0] f_logic_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = ~(x & y);
            3'd1:    r = ~x;
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            3'd4:    r = x ^ y;
            3'd5:    r = ~(x | y);
            3'd6:    r = ~(x ^ y);
            3'd7:    r = x & ~y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Even-parity helper: 1 when the word has an odd number of ones.
    function automatic logic f_parity(input logic [WIDTH-1:0] x);
        return ^x;
    endfunction

    logic                 s1_valid_r;
    logic [2:0]           s1_op_r;
    logic [WIDTH-1:0]     s1_a_r;
    logic [WIDTH-1:0]     s1_b_r;
    logic                 s2_valid_r;
    logic [WIDTH-1:0]     out_r;
    logic                 zr_r;
    logic                 ng_r;
    logic                 par_r;
    logic [CNT_WIDTH-1:0] count_r;

    logic                 s2_adv_s;
    logic                 s1_move_s;
    logic                 accept_s;
    logic                 handshake_s;
    logic [WIDTH-1:0]     result_s;

    // Advance/handshake decisions; in_ready depends only on state and out_ready.
    always_comb begin
        s2_adv_s    = 1'b0;
        s1_move_s   = 1'b0;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        in_ready    = 1'b0;
        if (!s2_valid_r || out_ready) begin
            s2_adv_s = 1'b1;
        end else begin
            s2_adv_s = 1'b0;
        end
        s1_move_s   = s1_valid_r && s2_adv_s;
        in_ready    = !s1_valid_r || s2_adv_s;
        accept_s    = in_valid && in_ready;
        handshake_s = s2_valid_r && out_ready;
    end

    // Stage-2 combinational result computed from the captured operands.
    always_comb begin
        result_s = '0;
        result_s = f_logic_op(s1_op_r, s1_a_r, s1_b_r);
    end

    // Stage 1: capture operands on accept, empty when the beat moves on.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'd0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= op;
            s1_a_r     <= a;
            s1_b_r     <= b;
        end else if (s1_move_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: register result and flags; hold them while stalled or empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            out_r      <= '0;
            zr_r       <= 1'b0;
            ng_r       <= 1'b0;
            par_r      <= 1'b0;
        end else if (s1_move_s) begin
            s2_valid_r <= 1'b1;
            out_r      <= result_s;
            zr_r       <= (result_s == '0);
            ng_r       <= result_s[WIDTH-1];
            par_r      <= f_parity(result_s);
        end else if (handshake_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Completed-handshake counter, wraps modulo 2^CNT_WIDTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (handshake_s) begin
            count_r <= count_r + CNT_WIDTH'(1'b1);
        end
    end

    assign out_valid = s2_valid_r;
    assign out       = out_r;
    assign zr        = zr_r;
    assign ng        = ng_r;
    assign par       = par_r;
    assign out_count = count_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: three instances (WIDTH 16/8/1) share the
// handshake controls; a queue-based reference model predicts every output.
module tb_logic_unit_pipe;

    logic        clock;
    logic        reset_s;
    logic        in_valid_s;
    logic        out_ready_s;
    logic [2:0]  op_s;
    logic [63:0] a_s;
    logic [63:0] b_s;

    logic        in_ready16, out_valid16, zr16, ng16, par16;
    logic [15:0] out16;
    logic [3:0]  cnt16;
    logic        in_ready8, out_valid8, zr8, ng8, par8;
    logic [7:0]  out8;
    logic [15:0] cnt8;
    logic        in_ready1, out_valid1, zr1, ng1, par1;
    logic [0:0]  out1;
    logic [7:0]  cnt1;

    logic_unit_pipe #(.WIDTH(16), .CNT_WIDTH(4)) dut16 (
        .clock(clock), .reset(reset_s), .in_valid(in_valid_s), .in_ready(in_ready16),
        .op(op_s), .a(a_s[15:0]), .b(b_s[15:0]), .out_valid(out_valid16),
        .out_ready(out_ready_s), .out(out16), .zr(zr16), .ng(ng16), .par(par16),
        .out_count(cnt16));

    logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
        .clock(clock), .reset(reset_s), .in_valid(in_valid_s), .in_ready(in_ready8),
        .op(op_s), .a(a_s[7:0]), .b(b_s[7:0]), .out_valid(out_valid8),
        .out_ready(out_ready_s), .out(out8), .zr(zr8), .ng(ng8), .par(par8),
        .out_count(cnt8));

    logic_unit_pipe #(.WIDTH(1), .CNT_WIDTH(8)) dut1 (
        .clock(clock), .reset(reset_s), .in_valid(in_valid_s), .in_ready(in_ready1),
        .op(op_s), .a(a_s[0:0]), .b(b_s[0:0]), .out_valid(out_valid1),
        .out_ready(out_ready_s), .out(out1), .zr(zr1), .ng(ng1), .par(par1),
        .out_count(cnt1));

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        zr;
        logic        ng;
        logic        par;
    } vec_t;

    beat_t q[$];
    vec_t  tbl[10];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    model_cnt = 0;
    int    edge_cnt = 0;
    bit    checking = 1'b0;
    bit    last_acc;
    bit    last_hs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden bitwise result truncated to w bits.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [63:0] x,
                                            input logic [63:0] y, input int w);
        logic [63:0] r;
        logic [63:0] mask;
        case (o)
            3'd0:    r = ~(x & y);
            3'd1:    r = ~x;
            3'd2:    r = x & y;
            3'd3:    r = x | y;
            3'd4:    r = x ^ y;
            3'd5:    r = ~(x | y);
            3'd6:    r = ~(x ^ y);
            default: r = x & ~y;
        endcase
        mask = (w >= 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
        return r & mask;
    endfunction

    task automatic check_res(input string tag, input int w, input logic [63:0] o,
                             input logic z, input logic n, input logic p, input beat_t bt);
        logic [63:0] r;
        r = ref_res(bt.op, bt.a, bt.b, w);
        check({tag, "_out"}, o, r);
        check({tag, "_zr"}, 64'(z), 64'(r == 64'd0));
        check({tag, "_ng"}, 64'(n), (r >> (w - 1)) & 64'd1);
        check({tag, "_par"}, 64'(p), 64'($countones(r) % 2));
    endtask

    // One clock cycle: check DUT against the model, then advance the model.
    task automatic cycle();
        bit m_valid, m_ready, hs, acc;
        @(negedge clock);
        m_valid = (q.size() > 0) && (q[0].cyc + 1 < edge_cnt);
        m_ready = (q.size() < 2) || out_ready_s;
        if (checking) begin
            check("in_ready16", 64'(in_ready16), 64'(m_ready));
            check("in_ready8", 64'(in_ready8), 64'(m_ready));
            check("in_ready1", 64'(in_ready1), 64'(m_ready));
            check("out_valid16", 64'(out_valid16), 64'(m_valid));
            check("out_valid8", 64'(out_valid8), 64'(m_valid));
            check("out_valid1", 64'(out_valid1), 64'(m_valid));
            check("count16", 64'(cnt16), 64'(model_cnt % 16));
            check("count8", 64'(cnt8), 64'(model_cnt % 65536));
            check("count1", 64'(cnt1), 64'(model_cnt % 256));
            if (m_valid) begin
                check_res("w16", 16, 64'(out16), zr16, ng16, par16, q[0]);
                check_res("w8", 8, 64'(out8), zr8, ng8, par8, q[0]);
                check_res("w1", 1, 64'(out1), zr1, ng1, par1, q[0]);
            end
        end
        hs  = m_valid && out_ready_s;
        acc = in_valid_s && m_ready;
        last_hs  = hs && !reset_s;
        last_acc = acc && !reset_s;
        if (reset_s) begin
            q.delete();
            model_cnt = 0;
        end else begin
            if (hs) begin
                void'(q.pop_front());
                model_cnt++;
            end
            if (acc) q.push_back('{op_s, a_s, b_s, edge_cnt});
        end
        edge_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_s = 1'b1;
        in_valid_s = 1'b0;
        cycle();
        reset_s = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        in_valid_s  = 1'b0;
        out_ready_s = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 20) begin
            cycle();
            k++;
        end
        check({name, "_drain_timeout"}, 64'(q.size()), 64'd0);
    endtask

    logic [15:0] held;
    int          j;
    int          hs_sum;
    int          acc_n;
    int          cyc_n;

    initial begin
        reset_s = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b1;
        op_s = 3'd0; a_s = 64'd0; b_s = 64'd0;

        tbl[0] = '{3'd0, 16'h00FF, 16'h0F0F, 16'hFFF0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3'd1, 16'h00FF, 16'h0F0F, 16'hFF00, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3'd3, 16'h00FF, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{3'd4, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{3'd5, 16'h00FF, 16'h0F0F, 16'hF000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{3'd6, 16'h00FF, 16'h0F0F, 16'hF00F, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{3'd7, 16'h00FF, 16'h0F0F, 16'h00F0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{3'd2, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};

        // Reset then idle.
        cycle();
        cycle();
        reset_s = 1'b0;
        checking = 1'b1;
        check("rst_out_valid", 64'(out_valid16), 64'd0);
        check("rst_in_ready", 64'(in_ready16), 64'd1);
        check("rst_out", 64'(out16), 64'd0);
        check("rst_zr", 64'(zr16), 64'd0);
        check("rst_ng", 64'(ng16), 64'd0);
        check("rst_par", 64'(par16), 64'd0);
        check("rst_count", 64'(cnt16), 64'd0);
        cycle();

        // Op sweep and flag vectors, one beat per cycle.
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                in_valid_s = 1'b1;
                op_s = tbl[i].op;
                a_s = 64'(tbl[i].a);
                b_s = 64'(tbl[i].b);
            end else begin
                in_valid_s = 1'b0;
            end
            cycle();
            if (i >= 1 && i <= 10) begin
                check($sformatf("vec%0d_valid", i - 1), 64'(out_valid16), 64'd1);
                check($sformatf("vec%0d_out", i - 1), 64'(out16), 64'(tbl[i-1].res));
                check($sformatf("vec%0d_zr", i - 1), 64'(zr16), 64'(tbl[i-1].zr));
                check($sformatf("vec%0d_ng", i - 1), 64'(ng16), 64'(tbl[i-1].ng));
                check($sformatf("vec%0d_par", i - 1), 64'(par16), 64'(tbl[i-1].par));
            end
        end
        check("vec_count", 64'(cnt16), 64'd10);
        check("hold_valid", 64'(out_valid16), 64'd0);
        check("hold_out", 64'(out16), 64'h0000);
        check("hold_zr", 64'(zr16), 64'd1);

        // Back-pressure: four beats, out_ready low.
        out_ready_s = 1'b0;
        j = 0;
        held = 16'h0;
        for (int k = 0; k < 6; k++) begin
            in_valid_s = 1'b1;
            op_s = 3'(j + 3);
            a_s = 64'h0000_0000_0000_A5C3 + 64'(j);
            b_s = 64'h0000_0000_0000_3CF0 ^ 64'(j << 4);
            cycle();
            if (last_acc) j++;
            if (k == 1) held = out16;
            if (k >= 2) check("bp_stable", 64'(out16), 64'(held));
        end
        check("bp_accepted", 64'(j), 64'd2);
        check("bp_in_ready", 64'(in_ready16), 64'd0);
        out_ready_s = 1'b1;
        hs_sum = 0;
        for (int k = 0; k < 4; k++) begin
            check("bp_no_gap", 64'(out_valid16), 64'd1);
            in_valid_s = (j < 4);
            op_s = 3'(j + 3);
            a_s = 64'h0000_0000_0000_A5C3 + 64'(j);
            b_s = 64'h0000_0000_0000_3CF0 ^ 64'(j << 4);
            cycle();
            if (last_acc) j++;
            if (last_hs) hs_sum++;
        end
        check("bp_released", 64'(hs_sum), 64'd4);
        check("bp_all_in", 64'(j), 64'd4);
        drain("bp");

        // Reset with both stages full.
        out_ready_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_s = 1'b1;
            op_s = 3'd3;
            a_s = 64'(16'h1111 << k);
            b_s = 64'h0000_0000_0000_0F00;
            cycle();
        end
        check("mid_full_valid", 64'(out_valid16), 64'd1);
        reset_s = 1'b1;
        out_ready_s = 1'b1;
        cycle();
        reset_s = 1'b0;
        check("mid_out_valid", 64'(out_valid16), 64'd0);
        check("mid_count", 64'(cnt16), 64'd0);
        check("mid_in_ready", 64'(in_ready16), 64'd1);
        in_valid_s = 1'b1;
        op_s = 3'd1;
        a_s = 64'h0000_0000_0000_F0F0;
        b_s = 64'h0;
        cycle();
        in_valid_s = 1'b0;
        cycle();
        check("mid_own_result", 64'(out16), 64'h0F0F);
        drain("mid");
        cycle();
        check("mid_single", 64'(cnt16), 64'd1);

        // Counter wrap on the 4-bit counter.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            in_valid_s = 1'b1;
            op_s = 3'(k % 8);
            a_s = 64'(k * 16'h0123);
            b_s = 64'(~k);
            cycle();
        end
        drain("wrap");
        check("wrap_count16", 64'(cnt16), 64'd1);
        check("wrap_count8", 64'(cnt8), 64'd17);

        // Random soak.
        do_reset();
        acc_n = 0;
        cyc_n = 0;
        while (acc_n < 1000 && cyc_n < 20000) begin
            in_valid_s  = ($urandom_range(0, 3) != 0);
            out_ready_s = ($urandom_range(0, 3) != 0);
            op_s = 3'($urandom_range(0, 7));
            a_s = {$urandom, $urandom};
            b_s = {$urandom, $urandom};
            cycle();
            if (last_acc) acc_n++;
            cyc_n++;
        end
        check("soak_accepted", 64'(acc_n), 64'd1000);
        drain("soak");
        cycle();
        check("soak_count8", 64'(cnt8), 64'(1000 % 65536));
        check("soak_count1", 64'(cnt1), 64'(1000 % 256));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit: the WIDTH-bit, multi-op, registered successor to the single-bit Nand/Not/And/Or/Xor gates.
- Two-stage pipeline with valid/ready handshakes on both sides, registered status flags and a completed-transaction counter.
- Sits between the operand source (sequencer or testbench driver) and the downstream consumer.
- Sustains one operation per cycle when not back-pressured.

Parameters:
WIDTH, 16, operand/result width in bits (legal range 1..64)
CNT_WIDTH, 16, width of the completed-transaction counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
op  input  3  operation select, sampled with a/b
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  result
zr  output  1  out == 0
ng  output  1  out[WIDTH-1]
par  output  1  XOR-reduction of out
out_count  output  CNT_WIDTH  number of completed output handshakes

Behaviour:
- Clocking: single clock; all state updates on the rising edge of clock.
- Reset: synchronous, active-high. Highest priority over any handshake in the same cycle.
  - Clears s1_valid, s2_valid, out, zr, ng, par and out_count to 0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - A reset asserted mid-operation discards all in-flight beats; no output handshake completes in that cycle.
- Op encoding (bitwise over WIDTH bits):
  - 0 NAND ~(a&b)
  - 1 NOT ~a (b ignored)
  - 2 AND a&b
  - 3 OR a|b
  - 4 XOR a^b
  - 5 NOR ~(a|b)
  - 6 XNOR ~(a^b)
  - 7 ANDN a&~b
- Stage 1 (capture):
  - Registers op, a and b when in_valid && in_ready.
  - Sets s1_valid.
- Stage 2 (compute):
  - Computes the result and flags from the stage-1 registers.
  - Registers them into out/zr/ng/par when stage 1 advances.
  - Sets s2_valid; out_valid = s2_valid.
- Advance rules, evaluated combinationally each cycle:
  - s2_adv = !s2_valid || out_ready
  - s1 moves into s2 when s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (no combinational path from in_valid to in_ready)
  - If s2_adv is true and s1 is empty, s2_valid clears on the cycle out_valid && out_ready completes.
- Latency and throughput:
  - Accept at edge N gives out_valid=1 after edge N+1, i.e. two cycles of latency.
  - Back-to-back accepts produce back-to-back results when out_ready=1.
- Stall:
  - out_ready=0 with out_valid=1 holds out, zr, ng and par stable.
  - Stage 1 still fills if empty, giving 2 beats of buffering; in_ready then drops to 0.
  - When out_ready returns to 1, in_ready rises in the same cycle (pass-through).
- Simultaneous events:
  - Accept into s1, s1→s2 transfer and output handshake can all occur in one cycle with no beat lost or duplicated.
- Ordering: results leave in acceptance order; nothing is dropped.
- Data hold:
  - out/flags hold their last value when s2 is empty.
  - Consumers qualify with out_valid.
- Counter:
  - out_count increments by 1 on every out_valid && out_ready.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no sticky flag.
- Width rules:
  - All results are exactly WIDTH bits; no carries.
  - For WIDTH=1, ng == out.

Test Plan:
- Reset then idle, WIDTH=16:
  - Required: out_valid=0, in_ready=1, out=0, zr=0, out_count=0.
- Op sweep with a=16'h00FF, b=16'h0F0F, out_ready=1, one beat per cycle, op 0..7:
  - Required results in order: FFF0, FF00, 000F, 0FFF, 0FF0, F000, F00F, 00F0.
  - Each result appears 2 cycles after its accept; out_count ends at 8.
- Flags:
  - op=2, a=16'h8000, b=16'hFFFF → out=8000, ng=1, par=1, zr=0.
  - op=4, a=b=16'h1234 → out=0000, zr=1, ng=0, par=0.
- Back-pressure: hold out_ready=0 and stream 4 beats.
  - Required: exactly 2 beats accepted, then in_ready=0; out stays stable.
  - Release out_ready: all 4 results emerge in order, one per cycle, with no gaps or duplicates.
- Reset mid-stream: assert reset for 1 cycle while s1 and s2 are both full.
  - Required next cycle: out_valid=0, out_count=0, in_ready=1.
  - The next accepted beat yields only its own result.
- Counter wrap with CNT_WIDTH=4: complete 17 handshakes → out_count=1.
- Random soak:
  - Stimulus: 1000 random op/a/b beats with random in_valid/out_ready, WIDTH=8 and WIDTH=1.
  - Required: scoreboard matches the golden bitwise model and order; out_count == completed beats mod 2^CNT_WIDTH.
